// File: rtl/gp_arb_pkg.sv
// gp_arb_pkg
// Shared definitions for the IO buffer arbiter: FSM state encoding and the
// widths of the hold and turnaround counters.
package gp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  // Hold counter covers HOLD_MAX up to 255; turnaround counter covers up to 15.
  localparam int HOLD_CNT_W = 8;
  localparam int TURN_CNT_W = 4;

endpackage

// File: rtl/gp_rr_pick.sv
// gp_rr_pick
// Combinational round-robin picker. Returns the first set request bit found
// searching upward from ptr+1, wrapping modulo NREQ.
// Ports:
//   req   [NREQ-1:0]  request vector
//   ptr   [IDX_W-1:0] index of the previous winner
//   valid             any request present
//   index [IDX_W-1:0] winning requester (0 when valid is low)
module gp_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest, so the nearest
  // set bit after ptr overwrites the rest.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/gp_iobuf_arbiter.sv
// gp_iobuf_arbiter
// Arbitrates NREQ requesters for one shared bidirectional pad. A single owner
// drives or samples the pad; ownership changes always pass through a
// TURNAROUND-cycle window with the output enable low.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   req      per-requester access request
//   drive    per-requester direction (1 drive, 0 sample)
//   dout     per-requester drive value
//   pad_out  pad value from the IO buffer
//   gnt      one-hot grant, zero when no owner
//   oe       IO buffer output enable
//   in       IO buffer drive value
//   rdata    registered pad sample
//   busy     high in GRANT or TURN
//
// state | meaning
// IDLE  | no owner; arbitrate on any request
// GRANT | owner holds the pad; hold counter runs
// TURN  | OE low between owners; last cycle arbitrates directly
module gp_iobuf_arbiter
  import gp_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int HOLD_MAX   = 15,
  parameter int TURNAROUND = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] drive,
  input  logic [NREQ-1:0] dout,
  input  logic            pad_out,
  output logic [NREQ-1:0] gnt,
  output logic            oe,
  output logic            in,
  output logic            rdata,
  output logic            busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM  = HOLD_CNT_W'(HOLD_MAX);
  localparam logic [TURN_CNT_W-1:0] TURN_INIT = TURN_CNT_W'(TURNAROUND - 1);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [HOLD_CNT_W-1:0]   hold_q, hold_d;
  logic [TURN_CNT_W-1:0]   turn_q, turn_d;
  logic [NREQ-1:0]         owner_oh;
  logic                    others_pending;
  logic                    arb_en;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;

  gp_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign owner_oh       = NREQ'(1) << owner_q;
  assign others_pending = |(req & ~owner_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(NREQ - 1);
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE: arb_en = 1'b1;
      GRANT: begin
        if (hold_q != HOLD_LIM) hold_d = hold_q + HOLD_CNT_W'(1);
        // Owner release and hold expiry can coincide; both lead to the same
        // single TURN entry.
        if (!req[owner_q] || (hold_q == HOLD_LIM && others_pending)) begin
          state_d = TURN;
          turn_d  = TURN_INIT;
        end
      end
      TURN: begin
        if (turn_q == '0) begin
          // Fold the IDLE arbitration into the last turnaround cycle so the
          // gap between owners is exactly TURNAROUND cycles.
          state_d = IDLE;
          arb_en  = 1'b1;
        end else begin
          turn_d = turn_q - TURN_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_en && pick_valid) begin
      state_d = GRANT;
      owner_d = pick_idx;
      ptr_d   = pick_idx;
      hold_d  = '0;
    end
  end

  // Outputs decode from the async-reset state, so reset drops OE at once.
  assign gnt  = (state_q == GRANT) ? owner_oh : '0;
  assign oe   = (state_q == GRANT) && drive[owner_q];
  assign in   = (state_q == GRANT) && dout[owner_q];
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 1'b0;
    end else if (state_q == GRANT && !oe) begin
      rdata <= pad_out;
    end
  end

endmodule
